// File: rtl/and4_bist_pkg.sv
// Shared types and constants for the and4gate BIST sequencer.
package and4_bist_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int         NUM_VEC     = 16;
   localparam logic [3:0] LAST_VEC    = 4'(NUM_VEC - 1);
   localparam logic [7:0] MISR_POLY   = 8'h1C;
   localparam logic [7:0] MISR_GOLDEN = 8'h1D;

   // One step of the response compactor: shift left, feed back the outgoing bit XOR the new sample.
   function automatic logic [7:0] misr_step(input logic [7:0] s, input logic d);
      logic fb;
      fb = s[7] ^ d;
      return {s[6:0], fb} ^ ({8{fb}} & MISR_POLY);
   endfunction

endpackage

// File: rtl/and4_bist_misr.sv
// 8-bit response signature register for the and4gate BIST; folds in one gate sample per enable.
module and4_bist_misr
   import and4_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       d_i,
   output logic [7:0] sig_o
);

   logic [7:0] sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else if (clr_i) begin
         sig_q <= '0;
      end else if (en_i) begin
         sig_q <= misr_step(sig_q, d_i);
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/and4_bist_ctrl.sv
// BIST sequencer for and4gate: sweeps all 16 vectors, samples f after a settle delay, logs errors.
// Define AND4_BIST_MISR_EN to add the 8-bit response signature output sig.
module and4_bist_ctrl
   import and4_bist_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             f_in,
   output logic [3:0]       vec,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       first_fail_vec,
   output logic             first_fail_valid
`ifdef AND4_BIST_MISR_EN
   ,
   output logic [7:0]       sig
`endif
);

   localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             pass_q, pass_d;
   logic [3:0]       ffv_q, ffv_d;
   logic             ffval_q, ffval_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
         ffv_q   <= '0;
         ffval_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         ffv_q   <= ffv_d;
         ffval_q <= ffval_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      pass_d  = pass_q;
      ffv_d   = ffv_q;
      ffval_d = ffval_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETTLE;
               vec_d   = '0;
               cnt_d   = SETTLE_RELOAD;
               err_d   = '0;
               pass_d  = 1'b0;
               ffv_d   = '0;
               ffval_d = 1'b0;
            end
         end
         SETTLE: begin
            if (cnt_q == 4'd0) state_d = SAMPLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         SAMPLE: begin
            if (f_in != (&vec_q)) begin
               err_d = err_q + 1'b1;
               if (!ffval_q) begin
                  ffv_d   = vec_q;
                  ffval_d = 1'b1;
               end
            end
            // pass is settled on entry to DONE so it is valid alongside the done pulse
            if (vec_q == LAST_VEC) begin
               state_d = DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = SETTLE;
               vec_d   = vec_q + 4'd1;
               cnt_d   = SETTLE_RELOAD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign vec              = vec_q;
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign pass             = pass_q;
   assign err_cnt          = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffval_q;

`ifdef AND4_BIST_MISR_EN
   and4_bist_misr u_misr (
      .clk   (clk),
      .rst   (rst),
      .clr_i ((state_q == IDLE) && start),
      .en_i  (state_q == SAMPLE),
      .d_i   (f_in),
      .sig_o (sig)
   );
`endif

endmodule

// File: tb/tb_and4_bist_ctrl.sv
// Randomized scoreboard bench for and4_bist_ctrl: two instances (settle 2 and settle 1) driven by gate fault models.
// Define AND4_BIST_MISR_EN to also check the signature output.
module tb_and4_bist_ctrl;

   typedef struct {
      int         cyc;
      logic       pass;
      logic [4:0] err;
      logic [3:0] ffv;
      logic       ffval;
      logic [7:0] sig;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       start;
   logic [1:0][15:0] mask;
   logic [1:0]       f_in;
   logic [1:0][3:0]  vec;
   logic [1:0]       busy, done, pass, ffval;
   logic [1:0][4:0]  err_cnt;
   logic [1:0][3:0]  ffv;
`ifdef AND4_BIST_MISR_EN
   logic [1:0][7:0]  sig;
`endif

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   res_t exp_q [2][$];
   int   rq    [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate model: correct AND, with each vector's response flipped where the fault mask has a 1.
   assign f_in[0] = (&vec[0]) ^ mask[0][vec[0]];
   assign f_in[1] = (&vec[1]) ^ mask[1][vec[1]];

   and4_bist_ctrl #(.SETTLE_CYC(2), .ERR_W(5)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .f_in(f_in[0]), .vec(vec[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
      .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0])
`ifdef AND4_BIST_MISR_EN
      , .sig(sig[0])
`endif
   );

   and4_bist_ctrl #(.SETTLE_CYC(1), .ERR_W(5)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .f_in(f_in[1]), .vec(vec[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
      .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1])
`ifdef AND4_BIST_MISR_EN
      , .sig(sig[1])
`endif
   );

   function automatic int sc(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int lat(input int d);
      return 16 * (sc(d) + 1);
   endfunction

   // Expected result of a full sweep under fault mask m; done expected at cycle c.
   function automatic res_t ref_run(input logic [15:0] m, input int c);
      res_t r;
      logic good, got, fb;
      r.cyc = c; r.err = '0; r.ffv = '0; r.ffval = 1'b0; r.sig = '0;
      for (int v = 0; v < 16; v++) begin
         good = (v == 15);
         got  = good ^ m[v];
         if (got != good) begin
            r.err++;
            if (!r.ffval) begin
               r.ffv   = 4'(v);
               r.ffval = 1'b1;
            end
         end
         fb    = r.sig[7] ^ got;
         r.sig = {r.sig[6:0], fb} ^ ({8{fb}} & 8'h1C);
      end
      r.pass = (r.err == 0);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_res(input int d, input res_t e);
      chk($sformatf("dut%0d done_cycle", d), cyc, e.cyc);
      chk($sformatf("dut%0d pass", d), pass[d], e.pass);
      chk($sformatf("dut%0d err_cnt", d), err_cnt[d], e.err);
      chk($sformatf("dut%0d first_fail_vec", d), ffv[d], e.ffv);
      chk($sformatf("dut%0d first_fail_valid", d), ffval[d], e.ffval);
      chk($sformatf("dut%0d busy_at_done", d), busy[d], 1);
`ifdef AND4_BIST_MISR_EN
      chk($sformatf("dut%0d sig", d), sig[d], e.sig);
`endif
   endtask

   task automatic rst_chk(input int d);
      chk($sformatf("dut%0d rst vec", d), vec[d], 0);
      chk($sformatf("dut%0d rst busy", d), busy[d], 0);
      chk($sformatf("dut%0d rst done", d), done[d], 0);
      chk($sformatf("dut%0d rst pass", d), pass[d], 0);
      chk($sformatf("dut%0d rst err_cnt", d), err_cnt[d], 0);
      chk($sformatf("dut%0d rst first_fail_vec", d), ffv[d], 0);
      chk($sformatf("dut%0d rst first_fail_valid", d), ffval[d], 0);
`ifdef AND4_BIST_MISR_EN
      chk($sformatf("dut%0d rst sig", d), sig[d], 0);
`endif
   endtask

   // Monitor: per-cycle vector/busy timeline plus scoreboard pop on every done pulse.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int d = 0; d < 2; d++) begin
            int   j;
            res_t e;
            while (rq[d].size() > 0 && (cyc - rq[d][0]) > lat(d) + 1) void'(rq[d].pop_front());
            if (rq[d].size() > 0 && cyc >= rq[d][0]) begin
               j = cyc - rq[d][0];
               if (j < lat(d)) begin
                  chk($sformatf("dut%0d vec j=%0d", d, j), vec[d], j / (sc(d) + 1));
                  chk($sformatf("dut%0d busy j=%0d", d, j), busy[d], 1);
                  chk($sformatf("dut%0d done_early j=%0d", d, j), done[d], 0);
               end else if (j == lat(d) + 1) begin
                  chk($sformatf("dut%0d idle busy", d), busy[d], 0);
                  chk($sformatf("dut%0d idle vec", d), vec[d], 15);
               end
            end
            if (done[d] === 1'b1) begin
               if (exp_q[d].size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL dut%0d done_unexpected: done=1 at cycle %0d, expected no done", d, cyc);
               end else begin
                  e = exp_q[d].pop_front();
                  chk_res(d, e);
               end
            end
         end
      end
   end

   // Start a sweep on the enabled instances; optionally poke start mid-run (must be ignored).
   task automatic launch(input logic [1:0] en, input logic [15:0] m0, input logic [15:0] m1,
                         input bit poke);
      int n;
      @(posedge clk); #2;
      n = cyc + 1;
      if (en[0]) begin
         mask[0] = m0;
         rq[0].push_back(n);
         exp_q[0].push_back(ref_run(m0, n + lat(0)));
      end
      if (en[1]) begin
         mask[1] = m1;
         rq[1].push_back(n);
         exp_q[1].push_back(ref_run(m1, n + lat(1)));
      end
      start = en;
      @(posedge clk); #2;
      start = '0;
      if (poke) begin
         repeat ($urandom_range(3, 25)) @(posedge clk);
         #2 start = en;
         @(posedge clk); #2;
         start = '0;
      end
      repeat (lat(0) + 4) @(posedge clk);
   endtask

   function automatic logic [15:0] rand_mask();
      case ($urandom_range(0, 3))
         0:       return 16'h0000;
         1:       return 16'($urandom());
         2:       return 16'h0001 << $urandom_range(0, 15);
         default: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      endcase
   endfunction

   initial begin
      int n;
      rst   = 1'b0;
      start = '0;
      mask  = '0;
      #1 rst = 1'b1;
      #2;
      rst_chk(0);
      rst_chk(1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      launch(2'b11, 16'h0000, 16'h0000, 1'b0);   // correct gate on both
      launch(2'b11, 16'h8000, 16'h7FFF, 1'b0);   // stuck-at-0 / stuck-at-1
      launch(2'b01, 16'h7FFF, 16'h0000, 1'b1);   // stuck-at-1 with an ignored mid-run start

      for (int i = 0; i < 6; i++) begin
         launch(2'b11, rand_mask(), rand_mask(), ($urandom_range(0, 1) != 0));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // start held high: back-to-back runs separated by one IDLE cycle
      @(posedge clk); #2;
      n = cyc + 1;
      mask[0] = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         rq[0].push_back(n + k * (lat(0) + 2));
         exp_q[0].push_back(ref_run(16'h0000, n + k * (lat(0) + 2) + lat(0)));
      end
      start[0] = 1'b1;
      repeat (120) @(posedge clk);
      #2 start[0] = 1'b0;
      repeat (lat(0) + 4) @(posedge clk);

      // asynchronous reset while vec=7 is settling
      @(posedge clk); #2;
      n = cyc + 1;
      mask[0] = 16'h7FFF;
      rq[0].push_back(n);
      start[0] = 1'b1;
      @(posedge clk); #2;
      start[0] = 1'b0;
      repeat (7 * (sc(0) + 1)) @(posedge clk);
      #2;
      chk("dut0 pre_rst vec", vec[0], 7);
      chk("dut0 pre_rst err_cnt", err_cnt[0], 7);
      chk("dut0 pre_rst first_fail_valid", ffval[0], 1);
      rst = 1'b1;
      #1;
      rst_chk(0);
      rst_chk(1);
      for (int d = 0; d < 2; d++) begin
         rq[d].delete();
         exp_q[d].delete();
      end
      @(posedge clk); #2 rst = 1'b0;
      launch(2'b11, 16'h0000, 16'h0000, 1'b0);

      repeat (4) @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         while (exp_q[d].size() > 0) begin
            res_t e;
            e = exp_q[d].pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL dut%0d done_missing: no done seen, expected done at cycle %0d", d, e.cyc);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
